// File: rtl/butterfly_lsu.sv
// Load/store unit between MEM and the data-memory bus: lane steering, strobes, load extension,
// valid/ready bus handshake with watchdog. Define LSU_MISALIGN_EXC_EN to trap misaligned accesses.
module butterfly_lsu #(
  parameter int ADDR_W  = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [RD_W-1:0]   req_rd_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic [RD_W-1:0]   rsp_rd_o,
  output logic [1:0]        rsp_err_o,
  output logic              dmem_valid_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_wdata_o,
  output logic [3:0]        dmem_wstrb_o,
  input  logic [31:0]       dmem_rdata_i,
  input  logic              dmem_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          off_q, off_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  // Request decode: size 11 collapses to word, lane offset follows the access size
  logic [1:0]  eff_size;
  logic [1:0]  eff_off;
  logic [3:0]  strb_c;
  logic [31:0] wdata_c;
  logic        misal;

  always_comb begin
    eff_size = (req_size_i == 2'b11) ? 2'b10 : req_size_i;
    eff_off  = 2'b00;
    strb_c   = 4'b1111;
    wdata_c  = req_wdata_i;
    case (eff_size)
      2'b00: begin
        eff_off = req_addr_i[1:0];
        strb_c  = 4'b0001 << eff_off;
        wdata_c = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        eff_off = {req_addr_i[1], 1'b0};
        strb_c  = 4'b0011 << eff_off;
        wdata_c = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
    if (!req_we_i) strb_c = 4'b0000;
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign misal = (req_size_i == 2'b11) ||
                 (req_size_i == 2'b01 && req_addr_i[0]) ||
                 (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // Load alignment and extension from the live bus word
  logic [31:0] shifted;
  logic [31:0] load_c;

  always_comb begin
    shifted = dmem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_c = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_c = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_c = dmem_rdata_i;
    endcase
  end

  logic to_hit;
  assign to_hit = (TIMEOUT > 0) && (cnt_q == TO_VAL);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = eff_size;
          uns_d   = req_unsigned_i;
          off_d   = eff_off;
          addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
          wdata_d = wdata_c;
          wstrb_d = strb_c;
          rd_d    = req_rd_i;
          rdata_d = 32'h0;
          if (misal) begin
            err_d   = ERR_MIS;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            cnt_d   = (TIMEOUT > 0) ? CW'(1) : '0;
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // Ready in the final watchdog cycle still counts as success
        if (dmem_ready_i) begin
          rdata_d = we_q ? 32'h0 : load_c;
          err_d   = ERR_OK;
          state_d = S_RESP;
        end else if (to_hit) begin
          rdata_d = 32'h0;
          err_d   = ERR_TO;
          state_d = S_RESP;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rd_q    <= '0;
      rdata_q <= 32'h0;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  logic in_bus, in_rsp;
  assign in_bus = (state_q == S_BUS);
  assign in_rsp = (state_q == S_RESP);

  assign req_ready_o  = (state_q == S_IDLE);
  assign dmem_valid_o = in_bus;
  assign dmem_we_o    = in_bus & we_q;
  assign dmem_addr_o  = in_bus ? addr_q  : '0;
  assign dmem_wdata_o = in_bus ? wdata_q : 32'h0;
  assign dmem_wstrb_o = in_bus ? wstrb_q : 4'h0;
  assign rsp_valid_o  = in_rsp;
  assign rsp_rdata_o  = in_rsp ? rdata_q : 32'h0;
  assign rsp_rd_o     = in_rsp ? rd_q    : '0;
  assign rsp_err_o    = in_rsp ? err_q   : 2'b00;

endmodule

// File: tb/tb_butterfly_lsu.sv
// Scoreboard bench for butterfly_lsu (TIMEOUT=4): directed loads/stores, wait states,
// watchdog expiry and boundary, misaligned handling, back-to-back issue, mid-op reset.
module tb_butterfly_lsu;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i, req_we_i, req_unsigned_i;
  logic        req_ready_o;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [4:0]  rsp_rd_o;
  logic [1:0]  rsp_err_o;
  logic        dmem_valid_o, dmem_we_o, dmem_ready_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_wstrb_o;

  butterfly_lsu #(.ADDR_W(32), .RD_W(5), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_rd_o(rsp_rd_o),
    .rsp_err_o(rsp_err_o),
    .dmem_valid_o(dmem_valid_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {logic [31:0] rdata; logic [4:0] rd; logic [1:0] err; int cyc;} rsp_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] strb; logic [31:0] wdata;} bus_t;

  rsp_t rq[$];
  bus_t bq[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int bdelay = 0, bcnt = 0;
  logic [31:0] brdata = 32'h0;
  logic prev_v = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bus model: ready after bdelay wait cycles, never if bdelay < 0
  always @(negedge clk_i) begin
    if (dmem_valid_o === 1'b1) begin
      dmem_ready_i = (bdelay >= 0) && (bcnt == bdelay);
      bcnt++;
    end else begin
      dmem_ready_i = 1'b0;
      bcnt = 0;
    end
    dmem_rdata_i = brdata;
  end

  // Bus-side monitor: check each new bus request against the expected one
  always @(negedge clk_i) begin
    if (dmem_valid_o === 1'b1 && !prev_v) begin
      if (bq.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
      end else begin
        bus_t e;
        e = bq.pop_front();
        chk("bus_addr", dmem_addr_o, e.addr);
        chk("bus_we", {31'h0, dmem_we_o}, {31'h0, e.we});
        chk("bus_wstrb", {28'h0, dmem_wstrb_o}, {28'h0, e.strb});
        if (e.we) chk("bus_wdata", dmem_wdata_o, e.wdata);
      end
    end
    prev_v = (dmem_valid_o === 1'b1);
  end

  // Response monitor
  always @(negedge clk_i) begin
    if (rsp_valid_o === 1'b1) begin
      if (rq.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
        chk("rsp_rd", {27'h0, rsp_rd_o}, {27'h0, e.rd});
        chk("rsp_err", {30'h0, rsp_err_o}, {30'h0, e.err});
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_bus_idle", {31'h0, dmem_valid_o}, 32'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input int delay, input logic [31:0] brd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_err,
                       input logic on_bus, input logic [31:0] exp_addr,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                       output int acc);
    int w;
    rsp_t r;
    bus_t b;
    int bc;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wd; req_rd_i = rd;
    w = 0;
    while (req_ready_o !== 1'b1 && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    acc = cyc;
    if (w >= 50) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid_i = 1'b0;
      return;
    end
    bdelay = delay;
    brdata = brd;
    bc = (delay < 0 || delay >= TO) ? TO : delay + 1;
    r.rdata = exp_rd; r.rd = rd; r.err = exp_err;
    r.cyc = on_bus ? cyc + 1 + bc : cyc + 1;
    rq.push_back(r);
    if (on_bus) begin
      b.addr = exp_addr; b.we = we; b.strb = exp_strb; b.wdata = exp_wd;
      bq.push_back(b);
    end
    @(posedge clk_i);
  endtask

  task automatic idle_req();
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((rq.size() != 0 || bq.size() != 0 || req_ready_o !== 1'b1) && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    chk("drain_rq_empty", rq.size(), 0);
    chk("drain_bq_empty", bq.size(), 0);
  endtask

  initial begin
    int a0, a1;
    rst_n_i = 1'b0;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'b00; req_unsigned_i = 1'b0;
    req_addr_i = 32'h0; req_wdata_i = 32'h0; req_rd_i = 5'h0;
    dmem_ready_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", {31'h0, req_ready_o}, 32'd1);
    chk("rst_dmem_valid", {31'h0, dmem_valid_o}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
    chk("rst_wstrb", {28'h0, dmem_wstrb_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    rst_n_i = 1'b1;

    // we size uns addr wdata rd delay busword exp_rdata err on_bus busaddr strb wdata
    issue(0, 2'b10, 0, 32'h100, 0, 5'd1, 0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b00, 0, 32'h103, 0, 5'd2, 0, 32'h80123456, 32'hFFFFFF80, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b00, 1, 32'h103, 0, 5'd3, 0, 32'h80123456, 32'h00000080, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b01, 1, 32'h102, 0, 5'd4, 0, 32'h80AB1234, 32'h000080AB, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b01, 0, 32'h102, 0, 5'd5, 0, 32'h80AB1234, 32'hFFFF80AB, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b00, 0, 32'h101, 0, 5'd6, 0, 32'h11227F44, 32'h0000007F, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 5'd7, 0, 0, 32'h0, 2'b00, 1, 32'h200, 4'b1100, 32'hABCDABCD, a0);
    issue(1, 2'b00, 0, 32'h201, 32'h00000055, 5'd8, 0, 0, 32'h0, 2'b00, 1, 32'h200, 4'b0010, 32'h55555555, a0);
    issue(1, 2'b10, 0, 32'h204, 32'hCAFEF00D, 5'd9, 1, 0, 32'h0, 2'b00, 1, 32'h204, 4'b1111, 32'hCAFEF00D, a0);
    issue(0, 2'b10, 0, 32'h108, 0, 5'd10, 2, 32'h11223344, 32'h11223344, 2'b00, 1, 32'h108, 4'h0, 0, a0);
    // watchdog: never ready -> timeout; ready in the 4th bus cycle -> success
    issue(0, 2'b10, 0, 32'h10C, 0, 5'd11, -1, 32'h55AA55AA, 32'h0, 2'b10, 1, 32'h10C, 4'h0, 0, a0);
    issue(0, 2'b10, 0, 32'h110, 0, 5'd12, 3, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 1, 32'h110, 4'h0, 0, a0);
    issue(1, 2'b00, 0, 32'h113, 32'h000000A5, 5'd13, -1, 0, 32'h0, 2'b10, 1, 32'h110, 4'b1000, 32'hA5A5A5A5, a0);
`ifdef LSU_MISALIGN_EXC_EN
    issue(0, 2'b10, 0, 32'h101, 0, 5'd14, 0, 32'h89ABCDEF, 32'h0, 2'b01, 0, 0, 4'h0, 0, a0);
    issue(0, 2'b01, 0, 32'h103, 0, 5'd15, 0, 32'h80AB1234, 32'h0, 2'b01, 0, 0, 4'h0, 0, a0);
    issue(1, 2'b10, 0, 32'h206, 32'h01020304, 5'd16, 0, 0, 32'h0, 2'b01, 0, 0, 4'h0, 0, a0);
    issue(1, 2'b11, 0, 32'h208, 32'h01020304, 5'd17, 0, 0, 32'h0, 2'b01, 0, 0, 4'h0, 0, a0);
`else
    issue(0, 2'b10, 0, 32'h101, 0, 5'd14, 0, 32'h89ABCDEF, 32'h89ABCDEF, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(0, 2'b01, 0, 32'h103, 0, 5'd15, 0, 32'h80AB1234, 32'hFFFF80AB, 2'b00, 1, 32'h100, 4'h0, 0, a0);
    issue(1, 2'b10, 0, 32'h206, 32'h01020304, 5'd16, 0, 0, 32'h0, 2'b00, 1, 32'h204, 4'b1111, 32'h01020304, a0);
    issue(1, 2'b11, 0, 32'h208, 32'h01020304, 5'd17, 0, 0, 32'h0, 2'b00, 1, 32'h208, 4'b1111, 32'h01020304, a0);
`endif
    // back-to-back zero-wait accepts every 3 cycles
    issue(0, 2'b10, 0, 32'h120, 0, 5'd18, 0, 32'h01234567, 32'h01234567, 2'b00, 1, 32'h120, 4'h0, 0, a0);
    issue(0, 2'b10, 0, 32'h124, 0, 5'd19, 0, 32'h76543210, 32'h76543210, 2'b00, 1, 32'h124, 4'h0, 0, a1);
    chk("b2b_accept_gap", a1 - a0, 3);
    idle_req();
    drain();

    // reset while stuck in BUS
    begin
      bus_t b;
      @(negedge clk_i);
      chk("pre_rst_ready", {31'h0, req_ready_o}, 32'd1);
      bdelay = -1;
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_addr_i = 32'h300; req_rd_i = 5'd20;
      b.addr = 32'h300; b.we = 1'b0; b.strb = 4'h0; b.wdata = 32'h0;
      bq.push_back(b);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("mid_op_busy", {31'h0, dmem_valid_o}, 32'd1);
      rst_n_i = 1'b0;
      #1;
      chk("rst_mid_dmem_valid", {31'h0, dmem_valid_o}, 32'd0);
      chk("rst_mid_dmem_addr", dmem_addr_o, 32'd0);
      chk("rst_mid_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_ready", {31'h0, req_ready_o}, 32'd1);
    end
    issue(0, 2'b00, 1, 32'h302, 0, 5'd21, 0, 32'h00C30000, 32'h000000C3, 2'b00, 1, 32'h300, 4'h0, 0, a0);
    idle_req();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
